// File: rtl/tx_pcs_encoder.sv
// 64b/66b transmit PCS encoder: pairs 32-bit XGMII words into columns, encodes and sequence-checks them.
// Optional self-synchronous payload scrambler enabled by defining TX_PCS_SCRAMBLER_EN.
`timescale 1ns/1ps
module tx_pcs_encoder #(
    parameter int unsigned ERR_CNT_WIDTH = 16,
    parameter logic [6:0]  IDLE_CODE7    = 7'h00,
    parameter logic [6:0]  ERROR_CODE7   = 7'h1E
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst,
    input  logic [31:0]              in_xgmii_data,
    input  logic [3:0]               in_xgmii_ctl,
    output logic                     out_xgmii_pcs_ready,
    output logic [1:0]               out_block_header,
    output logic [63:0]              out_block_payload,
    output logic                     out_block_valid,
    input  logic                     in_block_ready,
    output logic [ERR_CNT_WIDTH-1:0] out_err_count
);

    localparam logic [1:0] TX_C = 2'd0;
    localparam logic [1:0] TX_D = 2'd1;
    localparam logic [1:0] TX_E = 2'd2;

    localparam logic [2:0] K_C = 3'd0;
    localparam logic [2:0] K_S = 3'd1;
    localparam logic [2:0] K_T = 3'd2;
    localparam logic [2:0] K_D = 3'd3;
    localparam logic [2:0] K_E = 3'd4;

    localparam logic [1:0]  HDR_DATA = 2'b01;
    localparam logic [1:0]  HDR_CTRL = 2'b10;
    localparam logic [63:0] ERR_PAY  = {{8{ERROR_CODE7}}, 8'h1E};

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                     phase_p0;
    logic [31:0]              lo_data_p0;
    logic [3:0]               lo_ctl_p0;
    logic [1:0]               state_p1;
    logic [1:0]               state_nxt;
    logic [1:0]               hdr_p1;
    logic [63:0]              pay_p1;
    logic                     vld_p1;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_p1;

    logic        accept;
    logic        load;
    logic [63:0] col_data;
    logic [7:0]  col_ctl;
    logic [7:0]  lane [8];
    logic [6:0]  code [8];
    logic [7:0]  is_d;
    logic [7:0]  is_idle;
    logic [7:0]  is_c;
    logic [7:0]  is_t;
    logic [7:0]  t_hit;
    logic        s_lane0;
    logic        s_lane4;

    logic [2:0]  kind;
    logic [1:0]  enc_hdr;
    logic [63:0] enc_pay;
    logic        seq_ok;
    logic        blk_err;
    logic [1:0]  blk_hdr;
    logic [63:0] blk_pay;
    logic [63:0] tx_pay;

    // Stage p0: word acceptance and half-column capture
    assign out_xgmii_pcs_ready = !phase_p0 || !vld_p1 || in_block_ready;
    assign accept              = out_xgmii_pcs_ready;
    assign load                = accept && phase_p0;

    always_ff @(posedge tx_clk) begin
        if (accept && !phase_p0) begin
            lo_data_p0 <= in_xgmii_data;
            lo_ctl_p0  <= in_xgmii_ctl;
        end
    end

    assign col_data = {in_xgmii_data, lo_data_p0};
    assign col_ctl  = {in_xgmii_ctl, lo_ctl_p0};

    for (genvar g = 0; g < 8; g++) begin : g_lane
        // LO selects lanes below g, HI selects lanes above g
        localparam logic [7:0] LO = 8'hFF >> (8 - g);
        localparam logic [7:0] HI = 8'hFF << (g + 1);
        logic is_err;
        assign lane[g]    = col_data[8*g +: 8];
        assign is_d[g]    = !col_ctl[g];
        assign is_idle[g] = col_ctl[g] && (lane[g] == 8'h07);
        assign is_err     = col_ctl[g] && (lane[g] == 8'hFE);
        assign is_c[g]    = is_idle[g] || is_err;
        assign is_t[g]    = col_ctl[g] && (lane[g] == 8'hFD);
        assign code[g]    = is_idle[g] ? IDLE_CODE7 : ERROR_CODE7;
        assign t_hit[g]   = is_t[g] && ((is_d & LO) == LO) && ((is_idle & HI) == HI);
    end

    assign s_lane0 = col_ctl[0] && (lane[0] == 8'hFB);
    assign s_lane4 = col_ctl[4] && (lane[4] == 8'hFB);

    always_comb begin
        kind    = K_E;
        enc_hdr = HDR_CTRL;
        enc_pay = ERR_PAY;
        if (&is_d) begin
            kind    = K_D;
            enc_hdr = HDR_DATA;
            enc_pay = col_data;
        end else if (&is_c) begin
            kind    = K_C;
            enc_pay = {code[7], code[6], code[5], code[4], code[3], code[2], code[1], code[0], 8'h1E};
        end else if (s_lane0 && (&is_d[7:1])) begin
            kind    = K_S;
            enc_pay = {lane[7], lane[6], lane[5], lane[4], lane[3], lane[2], lane[1], 8'h78};
        end else if ((&is_c[3:0]) && s_lane4 && (&is_d[7:5])) begin
            kind    = K_S;
            enc_pay = {lane[7], lane[6], lane[5], 4'h0, code[3], code[2], code[1], code[0], 8'h33};
        end else begin
            // t_hit is one-hot: a second T would be neither data before it nor idle after it
            case (t_hit)
                8'h01: begin kind = K_T; enc_pay = {56'h0, 8'h87}; end
                8'h02: begin kind = K_T; enc_pay = {48'h0, lane[0], 8'h99}; end
                8'h04: begin kind = K_T; enc_pay = {40'h0, lane[1], lane[0], 8'hAA}; end
                8'h08: begin kind = K_T; enc_pay = {32'h0, lane[2], lane[1], lane[0], 8'hB4}; end
                8'h10: begin kind = K_T; enc_pay = {24'h0, lane[3], lane[2], lane[1], lane[0], 8'hCC}; end
                8'h20: begin kind = K_T; enc_pay = {16'h0, lane[4], lane[3], lane[2], lane[1], lane[0], 8'hD2}; end
                8'h40: begin kind = K_T; enc_pay = {8'h0, lane[5], lane[4], lane[3], lane[2], lane[1], lane[0], 8'hE1}; end
                8'h80: begin kind = K_T; enc_pay = {lane[6], lane[5], lane[4], lane[3], lane[2], lane[1], lane[0], 8'hFF}; end
                default: ;
            endcase
        end
    end

    always_comb begin
        seq_ok    = 1'b0;
        state_nxt = TX_E;
        case (state_p1)
            TX_C: begin
                if (kind == K_C)      begin seq_ok = 1'b1; state_nxt = TX_C; end
                else if (kind == K_S) begin seq_ok = 1'b1; state_nxt = TX_D; end
            end
            TX_D: begin
                if (kind == K_D)      begin seq_ok = 1'b1; state_nxt = TX_D; end
                else if (kind == K_T) begin seq_ok = 1'b1; state_nxt = TX_C; end
            end
            default: begin
                if (kind == K_C)      begin seq_ok = 1'b1; state_nxt = TX_C; end
                else if (kind == K_S) begin seq_ok = 1'b1; state_nxt = TX_D; end
            end
        endcase
    end

    assign blk_err = !seq_ok;
    assign blk_hdr = seq_ok ? enc_hdr : HDR_CTRL;
    assign blk_pay = seq_ok ? enc_pay : ERR_PAY;

`ifdef TX_PCS_SCRAMBLER_EN
    logic [57:0] scr_p1;
    logic [57:0] scr_nxt;

    // Bit 0 goes out first; st[0] holds the most recent scrambled bit
    function automatic logic [121:0] scramble(input logic [63:0] din, input logic [57:0] st_in);
        logic [63:0] d;
        logic [63:0] q;
        logic [57:0] st;
        logic        b;
        d  = din;
        st = st_in;
        q  = '0;
        for (int i = 0; i < 64; i++) begin
            b  = d[0] ^ st[38] ^ st[57];
            st = {st[56:0], b};
            q  = {b, q[63:1]};
            d  = d >> 1;
        end
        return {st, q};
    endfunction

    always_comb begin
        {scr_nxt, tx_pay} = scramble(blk_pay, scr_p1);
    end

    always_ff @(posedge tx_clk) begin
        if (!tx_rst) begin
            scr_p1 <= '1;
        end else if (load) begin
            scr_p1 <= scr_nxt;
        end
    end
`else
    assign tx_pay = blk_pay;
`endif

    // Stage p1: output block register, sequence state and error counter
    always_ff @(posedge tx_clk) begin
        if (!tx_rst) begin
            phase_p0   <= 1'b0;
            state_p1   <= TX_C;
            vld_p1     <= 1'b0;
            hdr_p1     <= HDR_CTRL;
            pay_p1     <= '0;
            err_cnt_p1 <= '0;
        end else begin
            if (accept) begin
                phase_p0 <= !phase_p0;
            end
            if (load) begin
                vld_p1   <= 1'b1;
                hdr_p1   <= blk_hdr;
                pay_p1   <= tx_pay;
                state_p1 <= state_nxt;
                if (blk_err) begin
                    err_cnt_p1 <= sat_inc(err_cnt_p1);
                end
            end else if (in_block_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_block_valid   = vld_p1;
    assign out_block_header  = hdr_p1;
    assign out_block_payload = pay_p1;
    assign out_err_count     = err_cnt_p1;

endmodule

// File: tb/tb_tx_pcs_encoder.sv
// Directed self-checking bench for tx_pcs_encoder (scrambler disabled, 3-bit error counter).
`timescale 1ns/1ps
module tb_tx_pcs_encoder;

    localparam logic [63:0] ERRP = 64'h3C78F1E3C78F1E1E;

    logic        tx_clk;
    logic        tx_rst;
    logic [31:0] in_xgmii_data;
    logic [3:0]  in_xgmii_ctl;
    logic        out_xgmii_pcs_ready;
    logic [1:0]  out_block_header;
    logic [63:0] out_block_payload;
    logic        out_block_valid;
    logic        in_block_ready;
    logic [2:0]  out_err_count;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    tx_pcs_encoder #(
        .ERR_CNT_WIDTH(3),
        .IDLE_CODE7   (7'h00),
        .ERROR_CODE7  (7'h1E)
    ) dut (
        .tx_clk             (tx_clk),
        .tx_rst             (tx_rst),
        .in_xgmii_data      (in_xgmii_data),
        .in_xgmii_ctl       (in_xgmii_ctl),
        .out_xgmii_pcs_ready(out_xgmii_pcs_ready),
        .out_block_header   (out_block_header),
        .out_block_payload  (out_block_payload),
        .out_block_valid    (out_block_valid),
        .in_block_ready     (in_block_ready),
        .out_err_count      (out_err_count)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    always @(posedge tx_clk) begin
        if (tx_rst && out_block_valid && in_block_ready) acc_cnt <= acc_cnt + 1;
    end

    // One column on consecutive edges; returns just after the edge that loads the block.
    task automatic col(input logic [31:0] d0, input logic [3:0] c0, input logic [31:0] d1, input logic [3:0] c1);
        @(negedge tx_clk); in_xgmii_data = d0; in_xgmii_ctl = c0;
        @(negedge tx_clk); in_xgmii_data = d1; in_xgmii_ctl = c1;
        @(posedge tx_clk); #1;
    endtask

    task automatic test_reset();
        tx_rst = 1'b0; in_block_ready = 1'b1;
        in_xgmii_data = 32'h07070707; in_xgmii_ctl = 4'hF;
        repeat (3) @(posedge tx_clk);
        #1 tx_rst = 1'b1;
        checks++; if ({out_block_valid, out_block_header, out_block_payload} !== {1'b0, 2'b10, 64'h0}) begin
            errors++; $display("FAIL reset_blk: got %b/%b/%h want 0/10/0", out_block_valid, out_block_header, out_block_payload); end
        checks++; if (out_err_count !== 3'd0) begin
            errors++; $display("FAIL reset_err: got %0d want 0", out_err_count); end
        checks++; if (out_xgmii_pcs_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", out_xgmii_pcs_ready); end
    endtask

    task automatic test_idle();
        col(32'h07070707, 4'hF, 32'h07070707, 4'hF);
        checks++; if ({out_block_valid, out_block_header, out_block_payload} !== {1'b1, 2'b10, 64'h1E}) begin
            errors++; $display("FAIL idle_blk: got %b/%b/%h want 1/10/1e", out_block_valid, out_block_header, out_block_payload); end
        checks++; if (out_err_count !== 3'd0) begin
            errors++; $display("FAIL idle_err: got %0d want 0", out_err_count); end
    endtask

    task automatic test_frame_s0_t4();
        col(32'h555555FB, 4'b0001, 32'h55555555, 4'h0);
        checks++; if ({out_block_header, out_block_payload} !== {2'b10, 64'h5555555555555578}) begin
            errors++; $display("FAIL start0: got %b/%h want 10/5555555555555578", out_block_header, out_block_payload); end
        col(32'h33221100, 4'h0, 32'h77665544, 4'h0);
        checks++; if ({out_block_header, out_block_payload} !== {2'b01, 64'h7766554433221100}) begin
            errors++; $display("FAIL data_blk: got %b/%h want 01/7766554433221100", out_block_header, out_block_payload); end
        col(32'hDDCCBBAA, 4'h0, 32'h070707FD, 4'hF);
        checks++; if ({out_block_header, out_block_payload} !== {2'b10, 64'h000000DDCCBBAACC}) begin
            errors++; $display("FAIL term4: got %b/%h want 10/000000ddccbbaacc", out_block_header, out_block_payload); end
        checks++; if (out_err_count !== 3'd0) begin
            errors++; $display("FAIL term4_err: got %0d want 0", out_err_count); end
    endtask

    task automatic test_frame_s4_t0_t7();
        col(32'h07070707, 4'hF, 32'hDDCCBBFB, 4'b0001);
        checks++; if ({out_block_header, out_block_payload} !== {2'b10, 64'hDDCCBB0000000033}) begin
            errors++; $display("FAIL start4: got %b/%h want 10/ddccbb0000000033", out_block_header, out_block_payload); end
        col(32'h070707FD, 4'hF, 32'h07070707, 4'hF);
        checks++; if ({out_block_header, out_block_payload} !== {2'b10, 64'h87}) begin
            errors++; $display("FAIL term0: got %b/%h want 10/87", out_block_header, out_block_payload); end
        col(32'h555555FB, 4'b0001, 32'h55555555, 4'h0);
        col(32'h33221100, 4'h0, 32'hFD665544, 4'b1000);
        checks++; if ({out_block_header, out_block_payload} !== {2'b10, 64'h66554433221100FF}) begin
            errors++; $display("FAIL term7: got %b/%h want 10/66554433221100ff", out_block_header, out_block_payload); end
        checks++; if (out_err_count !== 3'd0) begin
            errors++; $display("FAIL term7_err: got %0d want 0", out_err_count); end
    endtask

    task automatic test_encode_error();
        col(32'h07070755, 4'b0001, 32'h07070707, 4'hF);
        checks++; if ({out_block_header, out_block_payload} !== {2'b10, ERRP}) begin
            errors++; $display("FAIL enc_err_blk: got %b/%h want 10/%h", out_block_header, out_block_payload, ERRP); end
        checks++; if (out_err_count !== 3'd1) begin
            errors++; $display("FAIL enc_err_cnt: got %0d want 1", out_err_count); end
        col(32'h07070707, 4'hF, 32'h07070707, 4'hF);
        checks++; if ({out_block_header, out_block_payload} !== {2'b10, 64'h1E}) begin
            errors++; $display("FAIL recover_idle: got %b/%h want 10/1e", out_block_header, out_block_payload); end
        col(32'h07FE0707, 4'hF, 32'h07070707, 4'hF);
        checks++; if (out_block_payload !== 64'h000000000780001E) begin
            errors++; $display("FAIL xgmii_err_code: got %h want 000000000780001e", out_block_payload); end
        col(32'h555555FB, 4'b0001, 32'h55555555, 4'h0);
        col(32'hDDCCBBAA, 4'h0, 32'h07FE07FD, 4'hF);
        checks++; if ({out_block_header, out_block_payload, out_err_count} !== {2'b10, ERRP, 3'd2}) begin
            errors++; $display("FAIL t_nonidle: got %b/%h/%0d want 10/%h/2", out_block_header, out_block_payload, out_err_count, ERRP); end
        col(32'h07070707, 4'hF, 32'h07070707, 4'hF);
        col(32'h11111111, 4'h0, 32'h22222222, 4'h0);
        checks++; if ({out_block_header, out_block_payload, out_err_count} !== {2'b10, ERRP, 3'd3}) begin
            errors++; $display("FAIL data_in_c: got %b/%h/%0d want 10/%h/3", out_block_header, out_block_payload, out_err_count, ERRP); end
        col(32'h07070707, 4'hF, 32'h07070707, 4'hF);
    endtask

    task automatic test_backpressure();
        int a0;
        col(32'h07070707, 4'hF, 32'h07070707, 4'hF);
        @(negedge tx_clk);
        in_block_ready = 1'b0; in_xgmii_data = 32'h555555FB; in_xgmii_ctl = 4'b0001;
        @(negedge tx_clk);
        in_xgmii_data = 32'h55555555; in_xgmii_ctl = 4'h0;
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_xgmii_pcs_ready, out_block_valid, out_block_header, out_block_payload} !== {1'b0, 1'b1, 2'b10, 64'h1E}) begin
                errors++; $display("FAIL bp_hold%0d: got rdy=%b v=%b %b/%h want 0/1/10/1e", i, out_xgmii_pcs_ready, out_block_valid, out_block_header, out_block_payload); end
            @(negedge tx_clk);
        end
        checks++; if (acc_cnt !== a0) begin
            errors++; $display("FAIL bp_no_accept: got %0d want %0d", acc_cnt, a0); end
        in_block_ready = 1'b1;
        #1;
        checks++; if (out_xgmii_pcs_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b want 1", out_xgmii_pcs_ready); end
        @(posedge tx_clk); #1;
        checks++; if ({out_block_valid, out_block_header, out_block_payload} !== {1'b1, 2'b10, 64'h5555555555555578}) begin
            errors++; $display("FAIL bp_next_blk: got %b/%b/%h want 1/10/5555555555555578", out_block_valid, out_block_header, out_block_payload); end
        checks++; if (acc_cnt !== a0 + 1) begin
            errors++; $display("FAIL bp_one_accept: got %0d want %0d", acc_cnt, a0 + 1); end
        col(32'h33221100, 4'h0, 32'h77665544, 4'h0);
        checks++; if ({out_block_header, out_block_payload, acc_cnt} !== {2'b01, 64'h7766554433221100, a0 + 2}) begin
            errors++; $display("FAIL bp_after: got %b/%h acc=%0d want 01/7766554433221100 acc=%0d", out_block_header, out_block_payload, acc_cnt, a0 + 2); end
        col(32'h070707FD, 4'hF, 32'h07070707, 4'hF);
        checks++; if (out_block_payload !== 64'h87) begin
            errors++; $display("FAIL bp_term: got %h want 87", out_block_payload); end
    endtask

    task automatic test_saturation();
        logic [14:0] tab;
        tab = {3'd7, 3'd7, 3'd6, 3'd5, 3'd4};
        for (int i = 0; i < 5; i++) begin
            col(32'h11111111, 4'h0, 32'h22222222, 4'h0);
            checks++; if (out_err_count !== tab[3*i +: 3]) begin
                errors++; $display("FAIL sat%0d: got %0d want %0d", i, out_err_count, tab[3*i +: 3]); end
        end
        col(32'h07070707, 4'hF, 32'h07070707, 4'hF);
        checks++; if ({out_block_payload, out_err_count} !== {64'h1E, 3'd7}) begin
            errors++; $display("FAIL sat_hold: got %h/%0d want 1e/7", out_block_payload, out_err_count); end
    endtask

    task automatic test_reset_midframe();
        col(32'h555555FB, 4'b0001, 32'h55555555, 4'h0);
        @(negedge tx_clk); in_xgmii_data = 32'h12345678; in_xgmii_ctl = 4'h0;
        @(negedge tx_clk); tx_rst = 1'b0;
        @(posedge tx_clk); @(posedge tx_clk); #1 tx_rst = 1'b1;
        checks++; if ({out_block_valid, out_block_header, out_block_payload, out_err_count} !== {1'b0, 2'b10, 64'h0, 3'd0}) begin
            errors++; $display("FAIL midrst_state: got %b/%b/%h/%0d want 0/10/0/0", out_block_valid, out_block_header, out_block_payload, out_err_count); end
        col(32'h11111111, 4'h0, 32'h22222222, 4'h0);
        checks++; if ({out_block_valid, out_block_header, out_block_payload, out_err_count} !== {1'b1, 2'b10, ERRP, 3'd1}) begin
            errors++; $display("FAIL midrst_data: got %b/%b/%h/%0d want 1/10/%h/1", out_block_valid, out_block_header, out_block_payload, out_err_count, ERRP); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame_s0_t4();
        test_frame_s4_t0_t7();
        test_encode_error();
        test_backpressure();
        test_saturation();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
